// File: rtl/quiz_pkg.sv
// Shared definitions for the HexaQuiz round sequencer: state codes and datapath widths.
package quiz_pkg;

  localparam int HEX_W   = 4;
  localparam int SCORE_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQ_Q     = 3'd1;
  localparam logic [2:0] ST_ANSWER    = 3'd2;
  localparam logic [2:0] ST_CORRECT   = 3'd3;
  localparam logic [2:0] ST_WRONG     = 3'd4;
  localparam logic [2:0] ST_TIMEOUT   = 3'd5;
  localparam logic [2:0] ST_GAME_OVER = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_REQ_Q     = ST_REQ_Q,
    S_ANSWER    = ST_ANSWER,
    S_CORRECT   = ST_CORRECT,
    S_WRONG     = ST_WRONG,
    S_TIMEOUT   = ST_TIMEOUT,
    S_GAME_OVER = ST_GAME_OVER
  } state_t;

endpackage

// File: rtl/quiz_tick_gen.sv
// Seconds prescaler: down-counter that pulses sec_tick for one cycle every TICKS_PER_SEC cycles.
module quiz_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sec_tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= LOAD;
    else if (clear || cnt == '0) cnt <= LOAD;
    else cnt <= cnt - CW'(1);
  end

  // Terminal count reached after a full period since the last clear.
  assign sec_tick = !clear && (cnt == '0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// HexaQuiz round sequencer: question handshake, answer countdown, judging, score and lives.
//
// state     | meaning
// IDLE      | waiting for start
// REQ_Q     | q_req high, waiting for q_ready
// ANSWER    | countdown running, waiting for player answer
// CORRECT   | feedback hold after a matching answer
// WRONG     | feedback hold after a mismatching answer
// TIMEOUT   | feedback hold after countdown expiry
// GAME_OVER | score/lives frozen, waiting for start
module quiz_round_ctrl import quiz_pkg::*; #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ANSWER_SECS   = 15,
  parameter int FB_CYCLES     = 50_000_000,
  parameter int LIVES         = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               q_req,
  input  logic               q_ready,
  input  logic [HEX_W-1:0]   q_answer,
  input  logic               ans_valid,
  input  logic [HEX_W-1:0]   ans_value,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [4:0]         time_left
);

  localparam int FW = (FB_CYCLES > 1) ? $clog2(FB_CYCLES) : 1;
  localparam logic [FW-1:0] FB_LOAD = FW'(FB_CYCLES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
  localparam logic [4:0]    SECS_INIT  = 5'(ANSWER_SECS);

  state_t           st;
  logic [HEX_W-1:0] key;
  logic [FW-1:0]    fb_cnt;
  logic             sec_tick;

  quiz_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (st != S_ANSWER),
    .sec_tick (sec_tick)
  );

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= S_IDLE;
      q_req     <= 1'b0;
      score     <= '0;
      lives     <= LIVES_INIT;
      time_left <= '0;
      key       <= '0;
      fb_cnt    <= '0;
    end else begin
      case (st)
        S_IDLE, S_GAME_OVER: begin
          if (start) begin
            score <= '0;
            lives <= LIVES_INIT;
            st    <= S_REQ_Q;
            q_req <= 1'b1;
          end
        end
        S_REQ_Q: begin
          if (q_ready) begin
            key       <= q_answer;
            time_left <= SECS_INIT;
            st        <= S_ANSWER;
            q_req     <= 1'b0;
          end
        end
        S_ANSWER: begin
          // An answer takes priority over a tick in the same cycle.
          if (ans_valid) begin
            fb_cnt <= FB_LOAD;
            if (ans_value == key) begin
              st <= S_CORRECT;
              if (score != '1) score <= score + SCORE_W'(1);
            end else begin
              st <= S_WRONG;
              if (lives != 2'd0) lives <= lives - 2'd1;
            end
          end else if (sec_tick) begin
            time_left <= time_left - 5'd1;
            if (time_left == 5'd1) begin
              st     <= S_TIMEOUT;
              fb_cnt <= FB_LOAD;
              if (lives != 2'd0) lives <= lives - 2'd1;
            end
          end
        end
        S_CORRECT, S_WRONG, S_TIMEOUT: begin
          if (fb_cnt == '0) begin
            if (lives == 2'd0) begin
              st <= S_GAME_OVER;
            end else begin
              st    <= S_REQ_Q;
              q_req <= 1'b1;
            end
          end else begin
            fb_cnt <= fb_cnt - FW'(1);
          end
        end
        default: begin
          st    <= S_IDLE;
          q_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
